reg_file_gen2: RTL and testbench

Parametrised general-purpose register file for the single-cycle datapath: two combinational read ports, one clocked write port, configurable data width and depth. Adds what the first-generation file lacks: a synchronous reset that walks every register to zero through a clear sequencer, an optional hardwired zero register, and optional same-cycle write-to-read bypass. It sits between instruction decode (addresses) and the ALU/writeback mux (data), with `WE3` driven by the control unit's RegWrite.

---
 rtl/reg_file_gen2_pkg.sv | 6 +
 rtl/reg_file_gen2_if.sv | 11 +
 rtl/reg_file_clr_seq.sv | 27 ++
 rtl/reg_file_gen2.sv | 37 +++
 tb/tb_reg_file_gen2.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_gen2_pkg.sv
// reg_file_pkg: shared state type and default sizes for the gen2 register file.
package reg_file_pkg;
    typedef enum logic {CLEAR, RUN} rf_state_t;
    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;
endpackage

// File: rtl/reg_file_gen2_if.sv
// reg_file_gen2_if: read/write port bundle between decode/writeback and the register file.
interface reg_file_gen2_if import reg_file_pkg::*; #(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic [ADDR_W-1:0] A1, A2, A3;
    logic [DATA_W-1:0] WD3, RD1, RD2;
    logic              WE3, init_busy;
    modport master (output A1, A2, A3, WD3, WE3, input RD1, RD2, init_busy);
    modport slave  (input A1, A2, A3, WD3, WE3, output RD1, RD2, init_busy);
endinterface

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: after reset, walks every address once so the file starts all-zero.
module reg_file_clr_seq import reg_file_pkg::*; #(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_busy
);
    rf_state_t state;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            init_busy <= 1'b1;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + ADDR_W'(1);
            if (&clr_addr) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end
    end
    // No clearing progress while reset is held; the count restarts from 0.
    assign clr_en = (state == CLEAR) && !rst;
endmodule

// File: rtl/reg_file_gen2.sv
// reg_file_gen2: 2R/1W register file with clear sequencer, optional zero register and write bypass.
module reg_file_gen2 import reg_file_pkg::*; #(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic             clk,
    input logic             rst,
    reg_file_gen2_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              clr_en, busy, we;
    logic [ADDR_W-1:0] clr_addr, waddr;
    logic [DATA_W-1:0] wdata;
    reg_file_clr_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .init_busy(busy)
    );
    assign bus.init_busy = busy;
    // The sequencer owns the write port until the file is usable.
    always_comb begin
        waddr   = clr_en ? clr_addr : bus.A3;
        wdata   = clr_en ? '0 : bus.WD3;
        we      = clr_en || (!busy && !rst && bus.WE3 && !(ZERO_REG != 0 && bus.A3 == '0));
        bus.RD1 = (busy || (ZERO_REG != 0 && bus.A1 == '0)) ? '0 :
                  (BYPASS != 0 && bus.WE3 && bus.A1 == bus.A3) ? bus.WD3 : regs[bus.A1];
        bus.RD2 = (busy || (ZERO_REG != 0 && bus.A2 == '0)) ? '0 :
                  (BYPASS != 0 && bus.WE3 && bus.A2 == bus.A3) ? bus.WD3 : regs[bus.A2];
    end
    always_ff @(posedge clk)
        if (we) regs[waddr] <= wdata;
endmodule

// File: tb/tb_reg_file_gen2.sv
// tb_reg_file_gen2: three 16-bit variants (zero/bypass options) plus a 32x16 variant, checked against a storage-level model.
module tb_reg_file_gen2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  a1 = '0, a2 = '0, a3 = '0;
    logic [15:0] wd = '0;
    logic        we = 1'b0;
    logic [3:0]  wa1 = '0, wa2 = '0, wa3 = '0;
    logic [31:0] wwd = '0;
    logic        wwe = 1'b0;

    reg_file_gen2_if #(.DATA_W(16), .ADDR_W(3)) i0 ();
    reg_file_gen2_if #(.DATA_W(16), .ADDR_W(3)) i1 ();
    reg_file_gen2_if #(.DATA_W(16), .ADDR_W(3)) i2 ();
    reg_file_gen2_if #(.DATA_W(32), .ADDR_W(4)) iw ();

    reg_file_gen2 #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) d0 (.clk(clk), .rst(rst), .bus(i0));
    reg_file_gen2 #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) d1 (.clk(clk), .rst(rst), .bus(i1));
    reg_file_gen2 #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) d2 (.clk(clk), .rst(rst), .bus(i2));
    reg_file_gen2 #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dw (.clk(clk), .rst(rst), .bus(iw));

    assign {i0.A1, i0.A2, i0.A3, i0.WD3, i0.WE3} = {a1, a2, a3, wd, we};
    assign {i1.A1, i1.A2, i1.A3, i1.WD3, i1.WE3} = {a1, a2, a3, wd, we};
    assign {i2.A1, i2.A2, i2.A3, i2.WD3, i2.WE3} = {a1, a2, a3, wd, we};
    assign {iw.A1, iw.A2, iw.A3, iw.WD3, iw.WE3} = {wa1, wa2, wa3, wwd, wwe};

    logic [15:0] rd1 [3];
    logic [15:0] rd2 [3];
    logic        busy [3];
    assign rd1[0] = i0.RD1;
    assign rd1[1] = i1.RD1;
    assign rd1[2] = i2.RD1;
    assign rd2[0] = i0.RD2;
    assign rd2[1] = i1.RD2;
    assign rd2[2] = i2.RD2;
    assign busy[0] = i0.init_busy;
    assign busy[1] = i1.init_busy;
    assign busy[2] = i2.init_busy;

    bit zr [3] = '{1'b1, 1'b1, 1'b0};
    bit bp [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] m [3][8];
    bit mrun = 1'b0;
    int errs = 0;
    int checks = 0;

    function automatic logic [15:0] exp_rd(int c, logic [2:0] a);
        if (zr[c] && a == 3'd0) return 16'h0000;
        if (bp[c] && we && a == a3) return wd;
        return m[c][a];
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < 3; c++)
            if (mrun && we && !(zr[c] && a3 == 3'd0)) m[c][a3] = wd;
        #1;
    endtask

    task automatic count_clear(input int want_n, input int want_w);
        int nn [3];
        int nw;
        nn = '{-1, -1, -1};
        nw = -1;
        for (int n = 1; n <= 40 && (nn[0] < 0 || nn[1] < 0 || nn[2] < 0 || nw < 0); n++) begin
            tick();
            for (int c = 0; c < 3; c++) if (nn[c] < 0 && !busy[c]) nn[c] = n;
            if (nw < 0 && !iw.init_busy) nw = n;
            if (nn[0] >= 0) we = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (nn[c] !== want_n) begin
                errs++;
                $display("FAIL clear_len cfg%0d: got %0d cycles, want %0d", c, nn[c], want_n);
            end
        end
        checks++;
        if (nw !== want_w) begin
            errs++;
            $display("FAIL clear_len wide: got %0d cycles, want %0d", nw, want_w);
        end
        for (int c = 0; c < 3; c++) for (int r = 0; r < 8; r++) m[c][r] = 16'h0000;
        mrun = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy[c] !== 1'b1 || rd1[c] !== 16'h0 || rd2[c] !== 16'h0) begin
                errs++;
                $display("FAIL reset cfg%0d: busy=%b rd1=%h rd2=%h, want 1/0000/0000", c, busy[c], rd1[c], rd2[c]);
            end
        end
        rst = 1'b0;
        we = 1'b1; a3 = 3'd5; wd = 16'hBEEF; a1 = 3'd5; a2 = 3'd7;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy[c] !== 1'b1 || rd1[c] !== 16'h0 || rd2[c] !== 16'h0) begin
                errs++;
                $display("FAIL clear_forced cfg%0d: busy=%b rd1=%h rd2=%h, want 1/0000/0000", c, busy[c], rd1[c], rd2[c]);
            end
        end
        count_clear(8, 16);
        we = 1'b0;
        for (int r = 0; r < 8; r++) begin
            a1 = 3'(r); a2 = 3'(7 - r);
            #1;
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (rd1[c] !== 16'h0 || rd2[c] !== 16'h0) begin
                    errs++;
                    $display("FAIL cleared cfg%0d r%0d: rd1=%h rd2=%h, want 0000", c, r, rd1[c], rd2[c]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; a3 = 3'd3; wd = 16'h1234;
        tick();
        we = 1'b0; a1 = 3'd3; a2 = 3'd3;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rd1[c] !== 16'h1234 || rd2[c] !== 16'h1234) begin
                errs++;
                $display("FAIL write_read cfg%0d: rd1=%h rd2=%h, want 1234", c, rd1[c], rd2[c]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] want [3];
        we = 1'b1; a3 = 3'd4; wd = 16'h0004;
        tick();
        wd = 16'hA5A5; a1 = 3'd4;
        #1;
        want = '{16'hA5A5, 16'h0004, 16'hA5A5};
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rd1[c] !== want[c]) begin
                errs++;
                $display("FAIL bypass_same cfg%0d: rd1=%h, want %h", c, rd1[c], want[c]);
            end
        end
        tick();
        we = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rd1[c] !== 16'hA5A5) begin
                errs++;
                $display("FAIL bypass_next cfg%0d: rd1=%h, want a5a5", c, rd1[c]);
            end
        end
    endtask

    task automatic test_zero();
        logic [15:0] want [3];
        we = 1'b1; a3 = 3'd0; wd = 16'hFFFF; a1 = 3'd0; a2 = 3'd0;
        #1;
        want = '{16'h0000, 16'h0000, 16'hFFFF};
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rd1[c] !== want[c]) begin
                errs++;
                $display("FAIL zero_same cfg%0d: rd1=%h, want %h", c, rd1[c], want[c]);
            end
        end
        tick();
        we = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rd1[c] !== want[c] || rd2[c] !== want[c]) begin
                errs++;
                $display("FAIL zero_next cfg%0d: rd1=%h rd2=%h, want %h", c, rd1[c], rd2[c], want[c]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] e1, e2;
        for (int k = 0; k < 200; k++) begin
            a1 = 3'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 3'($urandom_range(0, 7));
            a3 = ($urandom_range(0, 2) == 0) ? a1 : 3'($urandom_range(0, 7));
            wd = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            #1;
            for (int c = 0; c < 3; c++) begin
                e1 = exp_rd(c, a1);
                e2 = exp_rd(c, a2);
                checks++;
                if (rd1[c] !== e1 || rd2[c] !== e2) begin
                    errs++;
                    $display("FAIL random k=%0d cfg%0d a1=%0d a2=%0d: rd1=%h rd2=%h, want %h %h", k, c, a1, a2, rd1[c], rd2[c], e1, e2);
                end
            end
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        we = 1'b1; a3 = 3'd2; wd = 16'h0022;
        tick();
        we = 1'b0; a1 = 3'd2;
        #1;
        checks++;
        if (rd1[0] !== 16'h0022) begin
            errs++;
            $display("FAIL pre_reset r2: rd1=%h, want 0022", rd1[0]);
        end
        mrun = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_clear(8, 16);
        a1 = 3'd2; a2 = 3'd2;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rd1[c] !== 16'h0 || rd2[c] !== 16'h0) begin
                errs++;
                $display("FAIL mid_clear r2 cfg%0d: rd1=%h rd2=%h, want 0000", c, rd1[c], rd2[c]);
            end
        end
    endtask

    task automatic test_wide();
        wwe = 1'b1; wa3 = 4'd15; wwd = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        wwe = 1'b0; wa1 = 4'd15; wa2 = 4'd14;
        #1;
        checks++;
        if (iw.RD1 !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL wide r15: rd1=%h, want deadbeef", iw.RD1);
        end
        checks++;
        if (iw.RD2 !== 32'h0) begin
            errs++;
            $display("FAIL wide r14: rd2=%h, want 00000000", iw.RD2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_random();
        test_reset_mid_clear();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
